// File: rtl/cmac_pkg.sv
// Shared widths and arithmetic helpers for the streaming complex dot-product engine.
// Widths are derived here so the top and any future wrappers agree on them.
package cmac_pkg;

    // Working width of the scaler; ACC_W must not exceed it.
    localparam int SC_W = 128;

    typedef struct packed {
        logic                   sat;
        logic signed [SC_W-1:0] val;
    } scaled_t;

    function automatic int acc_width(input int nbit, input int dim_max);
        return 2 * nbit + 1 + $clog2(dim_max);
    endfunction

    function automatic int len_width(input int dim_max);
        return $clog2(dim_max + 1);
    endfunction

    // A zero or out-of-range length means a full-length vector.
    function automatic int clamp_len(input int len, input int dim_max);
        if (len == 0 || len > dim_max)
            return dim_max;
        return len;
    endfunction

    // Floor-shift a signed in_w-bit value right, then saturate to a signed out_w range.
    function automatic scaled_t scale_sat(input logic signed [SC_W-1:0] x,
                                          input int in_w, input int shift, input int out_w);
        logic signed [SC_W-1:0] ext;
        logic signed [SC_W-1:0] shifted;
        logic signed [SC_W-1:0] max_v;
        logic signed [SC_W-1:0] min_v;
        scaled_t r;
        ext     = (x <<< (SC_W - in_w)) >>> (SC_W - in_w);
        shifted = ext >>> shift;
        max_v   = (SC_W'(1) <<< (out_w - 1)) - SC_W'(1);
        min_v   = ~max_v;
        r.sat   = 1'b0;
        r.val   = shifted;
        if (shifted > max_v) begin
            r.sat = 1'b1;
            r.val = max_v;
        end else if (shifted < min_v) begin
            r.sat = 1'b1;
            r.val = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmac_mult.sv
// Operand capture, four full-precision partial products, and the conj-selected
// complex sums. All three register stages advance together on en.
module cmac_mult #(
    parameter int NBIT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   in_conj,
    input  logic signed [NBIT-1:0] a_re,
    input  logic signed [NBIT-1:0] a_im,
    input  logic signed [NBIT-1:0] b_re,
    input  logic signed [NBIT-1:0] b_im,
    output logic                   s2_valid,
    output logic                   s2_last,
    output logic signed [2*NBIT:0] s2_re,
    output logic signed [2*NBIT:0] s2_im
);

    localparam int PW = 2 * NBIT;
    localparam int SW = PW + 1;

    logic                   s0_valid, s0_last, s0_conj;
    logic signed [NBIT-1:0] s0_a_re, s0_a_im, s0_b_re, s0_b_im;

    logic                   s1_valid, s1_last, s1_conj;
    logic signed [PW-1:0]   s1_rr, s1_ii, s1_ri, s1_ir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s0_conj  <= 1'b0;
            s0_a_re  <= '0;
            s0_a_im  <= '0;
            s0_b_re  <= '0;
            s0_b_im  <= '0;
        end else if (en) begin
            s0_valid <= in_valid;
            s0_last  <= in_last;
            s0_conj  <= in_conj;
            s0_a_re  <= a_re;
            s0_a_im  <= a_im;
            s0_b_re  <= b_re;
            s0_b_im  <= b_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_conj  <= 1'b0;
            s1_rr    <= '0;
            s1_ii    <= '0;
            s1_ri    <= '0;
            s1_ir    <= '0;
        end else if (en) begin
            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            s1_conj  <= s0_conj;
            s1_rr    <= PW'(s0_a_re) * PW'(s0_b_re);
            s1_ii    <= PW'(s0_a_im) * PW'(s0_b_im);
            s1_ri    <= PW'(s0_a_re) * PW'(s0_b_im);
            s1_ir    <= PW'(s0_a_im) * PW'(s0_b_re);
        end
    end

    // One extra bit keeps the sum of two products exact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_conj) begin
                s2_re <= SW'(s1_rr) + SW'(s1_ii);
                s2_im <= SW'(s1_ir) - SW'(s1_ri);
            end else begin
                s2_re <= SW'(s1_rr) - SW'(s1_ii);
                s2_im <= SW'(s1_ri) + SW'(s1_ir);
            end
        end
    end

endmodule

// File: rtl/cmac_dot.sv
// Streaming complex dot product: element counter, wide accumulator, scaled and
// saturated result register, and the input/output valid/ready handshake.
module cmac_dot
    import cmac_pkg::*;
#(
    parameter  int NBIT     = 32,
    parameter  int FRAC     = 27,
    parameter  int DIM_MAX  = 16,
    parameter  int OUT_W    = 32,
    parameter  int OUT_FRAC = 21,
    localparam int LW       = len_width(DIM_MAX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [NBIT-1:0]  a_re,
    input  logic signed [NBIT-1:0]  a_im,
    input  logic signed [NBIT-1:0]  b_re,
    input  logic signed [NBIT-1:0]  b_im,
    input  logic [LW-1:0]           len,
    input  logic                    conj,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    out_sat
);

    localparam int ACC_W = acc_width(NBIT, DIM_MAX);
    localparam int SHIFT = 2 * FRAC - OUT_FRAC;

    // Handshake: a beat transfers on an edge where valid & ready are both high.
    // Everything freezes only while a finished result waits for the consumer,
    // so a held result is never overwritten and in_ready mirrors that enable.
    logic en;
    logic accept;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic [LW-1:0] cnt, len_q, cur_len;
    logic          conj_q, cur_conj;
    logic          last;

    // Length and conj are taken from the bus on the first element only.
    always_comb begin
        cur_len  = len_q;
        cur_conj = conj_q;
        if (cnt == '0) begin
            cur_len  = LW'(clamp_len(int'(len), DIM_MAX));
            cur_conj = conj;
        end
    end

    assign last = (cnt == cur_len - LW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            len_q  <= '0;
            conj_q <= 1'b0;
        end else if (accept) begin
            if (cnt == '0) begin
                len_q  <= cur_len;
                conj_q <= cur_conj;
            end
            cnt <= last ? '0 : cnt + LW'(1);
        end
    end

    logic                   s2_valid, s2_last;
    logic signed [2*NBIT:0] s2_re, s2_im;

    cmac_mult #(
        .NBIT (NBIT)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_last  (last),
        .in_conj  (cur_conj),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .s2_valid (s2_valid),
        .s2_last  (s2_last),
        .s2_re    (s2_re),
        .s2_im    (s2_im)
    );

    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] tot_re, tot_im;
    scaled_t                 sc_re, sc_im;

    always_comb begin
        tot_re = acc_re + ACC_W'(s2_re);
        tot_im = acc_im + ACC_W'(s2_im);
        sc_re  = scale_sat({{(SC_W - ACC_W){tot_re[ACC_W-1]}}, tot_re}, ACC_W, SHIFT, OUT_W);
        sc_im  = scale_sat({{(SC_W - ACC_W){tot_im[ACC_W-1]}}, tot_im}, ACC_W, SHIFT, OUT_W);
    end

    // When en is high any current result is being consumed, so out_valid
    // simply follows whether a vector completes on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_re    <= '0;
            acc_im    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    acc_re    <= '0;
                    acc_im    <= '0;
                    out_valid <= 1'b1;
                    out_re    <= OUT_W'(sc_re.val);
                    out_im    <= OUT_W'(sc_im.val);
                    out_sat   <= sc_re.sat | sc_im.sat;
                end else begin
                    acc_re <= tot_re;
                    acc_im <= tot_im;
                end
            end
        end
    end

endmodule

// File: doc/cmac_dot.md
# cmac_dot

Parametrised streaming complex dot-product engine for the matrix-multiply datapath. Accepts one complex element pair (a, b) per cycle over a valid/ready handshake, forms a·b or a·conj(b) at full precision, accumulates over a runtime-selected vector length, and emits one scaled, saturated complex result per vector over a second valid/ready handshake. It sits between the operand ROM readout and the result RAM write port, replacing the fixed-length product/sum/accumulate chain.

## Interface
- NBIT, 32: operand width, signed two's complement.
- FRAC, 27: operand fractional bits (default Q5.27).
- DIM_MAX, 16: maximum vector length; LW = $clog2(DIM_MAX+1).
- OUT_W, 32: result width, signed.
- OUT_FRAC, 21: result fractional bits (default Q11.21); 2*FRAC-OUT_FRAC ≥ 0 is required.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  element pair present.
- in_ready  out  1  element pair accepted when in_valid & in_ready.
- a_re, a_im, b_re, b_im  in  NBIT each  operands.
- len  in  LW  vector length, sampled on the first element of each vector.
- conj  in  1  1 = a·conj(b), sampled with len.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_re, out_im  out  OUT_W each  scaled, saturated result.
- out_sat  out  1  either component of the current result saturated.

## Operation
- Element counter cnt counts 0..L-1, where L = len latched at cnt==0. len==0 or len>DIM_MAX is treated as DIM_MAX. The element at cnt==L-1 is tagged last, and cnt wraps to 0.
- S1 (registered): four full-precision 2*NBIT products a_re·b_re, a_im·b_im, a_re·b_im, a_im·b_re, plus valid, last, and conj tags.
- S2 (registered): sums at 2*NBIT+1 bits.
  - conj=0: re = rr - ii, im = ri + ir.
  - conj=1: re = rr + ii, im = ir - ri.
- S3: the accumulator has ACC_W = 2*NBIT+1+$clog2(DIM_MAX) bits with 2*FRAC fractional bits, so it never wraps.
  - On an S2 valid non-last item: acc += sum.
  - On an S2 valid last item: the result register loads scale(acc+sum), acc clears to 0, and out_valid sets.
- scale(x): arithmetic right shift by 2*FRAC-OUT_FRAC (truncation toward -inf), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat = sat_re | sat_im.
- Stall: en = !(out_valid & !out_ready). All stages, cnt, and acc advance only when en=1, and in_ready = en.
  - A held result is never overwritten.
  - With out_ready=1, a new result may load in the same cycle the old one is consumed.
- Back-to-back vectors need no gap. The accumulator clears and restarts seamlessly.

## Timing
- Reset (rst=0, asynchronous): every register clears. cnt=0, acc=0, pipeline valids=0, out_valid=0, out_re=out_im=0, out_sat=0. in_ready=1 from the first cycle after release.
- Latency: the last element accepted at edge k gives out_valid=1 after edge k+3, provided no stall occurs.
- Throughput: one element per cycle. With len=1, one result per cycle.
- out_valid clears after the edge where out_valid & out_ready, unless a new result loads on that edge.
- Reset asserted mid-vector discards the partial sum and any held result. The next accepted element starts a new vector with a freshly sampled len.

## Structure
- Package cmac_pkg holds:
  - ACC_W and LW width functions,
  - a clamp function for len,
  - a scale/saturate function parameterised by input width, shift, and OUT_W.
- Sub-module cmac_mult contains S1 and S2 (the four products and the conj-selected sums) with its own enable. cmac_dot holds the counter, accumulator, result register, and handshake.

## Test plan
- Single element: len=1, a=(1,0), b=(1,0), i.e. a_re=b_re=0x08000000 -> out_re=0x00200000, out_im=0, out_sat=0, out_valid 3 edges after accept.
- Length-3 vector: a=(1,1), b=(1,-1) each element.
  - conj=0 -> out_re=0x00C00000 (6.0), out_im=0.
  - Repeated with conj=1 -> out_re=0, out_im=0x00C00000.
- Back-pressure: two len=2 vectors streamed back-to-back with out_ready=0.
  - in_ready drops once the first result is held.
  - After out_ready=1, both results arrive in order and intact.
- Saturation: len=16, a=b=(0x7FFFFFFF,0) -> out_re=0x7FFFFFFF, out_sat=1. With a=(0x80000000,0) -> out_re=0x80000000, out_sat=1.
- Length edge cases: len=0 -> 16 elements accumulated. len=1 with continuous input and out_ready=1 -> out_valid stays high and gives one result per cycle.
- Reset mid-vector: rst=0 after 2 of 4 elements -> all outputs 0 immediately. A subsequent len=1, a=b=(1,0) vector -> out_re=0x00200000.
